sprite_layer: RTL and testbench

SPRITE_LAYER -- requirements
Module: sprite_layer

---
 rtl/sprite_layer_if.sv | 19 +
 rtl/sprite_layer.sv | 181 ++++++++++++++++++
 tb/tb_sprite_layer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_layer_if.sv
// Command/pixel bus between a display controller and one sprite layer.
interface sprite_layer_if;
    logic        write;
    logic [31:0] writedata;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [23:0] RGB_output;
    logic        hit;

    modport master (
        output write, writedata, hcount, vcount,
        input  RGB_output, hit
    );

    modport slave (
        input  write, writedata, hcount, vcount,
        output RGB_output, hit
    );
endinterface

// File: rtl/sprite_layer.sv
// Double-buffered sprite layer: per-child position/pattern state, animation phase,
// priority pixel selection and a two-stage ROM/palette pipeline.
module sprite_layer #(
    parameter logic [5:0]  COMPONENT_ID = 6'b000011,
    parameter int unsigned NUM_CHILDREN = 8,
    parameter int unsigned NUM_PATTERNS = 8,
    parameter int unsigned PAT_W        = 16,
    parameter int unsigned PAT_H        = 16,
    parameter int unsigned PALETTE_SIZE = 16,
    parameter int unsigned ANIM_DIV     = 8,
    parameter logic [23:0] BG_COLOR     = 24'h202020
) (
    input  logic           clk,
    input  logic           reset,
    sprite_layer_if.slave  bus
);

    localparam int unsigned MEM_DEPTH = NUM_PATTERNS * PAT_W * PAT_H;
    localparam int unsigned AW        = $clog2(MEM_DEPTH);
    localparam logic [5:0]  NP6       = 6'(NUM_PATTERNS);
    localparam logic [10:0] PW11      = 11'(PAT_W);
    localparam logic [10:0] PH11      = 11'(PAT_H);
    localparam logic [9:0]  PW_M1     = 10'(PAT_W - 1);
    localparam logic [7:0]  DIV_M1    = 8'(ANIM_DIV - 1);

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [4:0] pattern;
        logic       visible;
        logic       flip;
        logic       anim_en;
        logic [3:0] frames;
    } child_t;

    localparam child_t CHILD_RST = '{x: 10'd0, y: 10'd0, pattern: 5'd0, visible: 1'b0,
                                     flip: 1'b0, anim_en: 1'b0, frames: 4'd1};

    // Pattern and palette ROMs, fixed at elaboration as constant tables.
    logic [3:0]  rom [MEM_DEPTH];
    logic [23:0] pal [PALETTE_SIZE];

    for (genvar a = 0; a < MEM_DEPTH; a++) begin : g_rom
        assign rom[a] = 4'((a % PAT_W + (a / PAT_W) % PAT_H + 3 * (a / (PAT_W * PAT_H))) % 16);
    end

    for (genvar i = 0; i < PALETTE_SIZE; i++) begin : g_pal
        assign pal[i] = {4'(i), 4'hA, 8'(16 * i), 8'(255 - i)};
    end

    logic [5:0]  cmd_id;
    logic [4:0]  cmd_child;
    logic [3:0]  cmd_ctrl;
    logic [2:0]  cmd_type;
    logic        cmd_buf;
    logic [12:0] cmd_data;
    logic        swap_c, upd_c, pat_ok_c, frame_start_c, unused_c;
    logic [3:0]  frames_c;

    assign {cmd_id, cmd_child, cmd_ctrl, cmd_type, cmd_buf, cmd_data} = bus.writedata;
    assign swap_c        = bus.write && (cmd_ctrl == 4'hF);
    assign upd_c         = bus.write && (cmd_ctrl == 4'h1) && (cmd_id == COMPONENT_ID)
                           && ({1'b0, cmd_child} < 6'(NUM_CHILDREN));
    assign pat_ok_c      = {1'b0, cmd_data[4:0]} < NP6;
    assign frames_c      = (cmd_data[3:0] == 4'd0) ? 4'd1 : cmd_data[3:0];
    assign frame_start_c = (bus.hcount == 10'd0) && (bus.vcount == 10'd0);
    assign unused_c      = cmd_data[10];

    child_t     child_q [2][NUM_CHILDREN];
    logic       active_q;
    logic [3:0] phase_q;
    logic [7:0] frame_cnt_q;

    // Command decode, buffer swap and animation phase.
    always_ff @(posedge clk) begin
        if (!reset) begin
            active_q    <= 1'b0;
            phase_q     <= 4'd0;
            frame_cnt_q <= 8'd0;
            for (int unsigned b = 0; b < 2; b++)
                for (int unsigned c = 0; c < NUM_CHILDREN; c++)
                    child_q[b][c] <= CHILD_RST;
        end else begin
            if (frame_start_c) begin
                if (frame_cnt_q == DIV_M1) begin
                    frame_cnt_q <= 8'd0;
                    phase_q     <= phase_q + 4'd1;
                end else begin
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                end
            end
            if (swap_c) begin
                active_q <= cmd_buf;
                for (int unsigned c = 0; c < NUM_CHILDREN; c++)
                    child_q[~cmd_buf][c].visible <= 1'b0;
            end
            if (upd_c) begin
                for (int unsigned c = 0; c < NUM_CHILDREN; c++) begin
                    if (cmd_child == 5'(c)) begin
                        case (cmd_type)
                            3'd0: child_q[cmd_buf][c].x <= cmd_data[9:0];
                            3'd1: child_q[cmd_buf][c].y <= cmd_data[9:0];
                            3'd2: if (pat_ok_c) begin
                                child_q[cmd_buf][c].visible <= cmd_data[12];
                                child_q[cmd_buf][c].flip    <= cmd_data[11];
                                child_q[cmd_buf][c].pattern <= cmd_data[4:0];
                            end
                            3'd3: begin
                                child_q[cmd_buf][c].anim_en <= cmd_data[12];
                                child_q[cmd_buf][c].frames  <= frames_c;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    logic [10:0]         h11, v11;
    logic [NUM_CHILDREN-1:0] child_hit_c;
    logic [AW-1:0]       child_addr_c [NUM_CHILDREN];

    assign h11 = {1'b0, bus.hcount};
    assign v11 = {1'b0, bus.vcount};

    // Per-child coverage, animated pattern and ROM address in the active buffer.
    for (genvar gc = 0; gc < NUM_CHILDREN; gc++) begin : g_child
        child_t     ch;
        logic       covers;
        logic [9:0] dx, dy, col;
        logic [3:0] step;
        logic [5:0] sum, effpat;

        assign ch     = child_q[active_q][gc];
        assign covers = ch.visible
                        && (h11 >= {1'b0, ch.x}) && (h11 < ({1'b0, ch.x} + PW11))
                        && (v11 >= {1'b0, ch.y}) && (v11 < ({1'b0, ch.y} + PH11));
        assign dx     = bus.hcount - ch.x;
        assign dy     = bus.vcount - ch.y;
        assign col    = ch.flip ? (PW_M1 - dx) : dx;
        assign step   = ch.anim_en ? (phase_q % ch.frames) : 4'd0;
        assign sum    = 6'(ch.pattern) + 6'(step);
        assign effpat = (sum >= NP6) ? (sum - NP6) : sum;
        assign child_addr_c[gc] = AW'(32'(effpat) * PAT_W * PAT_H + 32'(dy) * PAT_W + 32'(col));
        assign child_hit_c[gc]  = covers && (rom[child_addr_c[gc]] != 4'd0);
    end

    logic          win_hit_c;
    logic [AW-1:0] win_addr_c;

    // Lowest-index hitting child wins.
    always_comb begin
        win_hit_c  = 1'b0;
        win_addr_c = '0;
        for (int unsigned c = NUM_CHILDREN; c > 0; c--) begin
            if (child_hit_c[c-1]) begin
                win_hit_c  = 1'b1;
                win_addr_c = child_addr_c[c-1];
            end
        end
    end

    logic          s1_hit_q;
    logic [AW-1:0] s1_addr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_hit_q       <= 1'b0;
            s1_addr_q      <= '0;
            bus.hit        <= 1'b0;
            bus.RGB_output <= BG_COLOR;
        end else begin
            s1_hit_q       <= win_hit_c;
            s1_addr_q      <= win_addr_c;
            bus.hit        <= s1_hit_q;
            bus.RGB_output <= s1_hit_q ? pal[rom[s1_addr_q]] : BG_COLOR;
        end
    end

endmodule

// File: tb/tb_sprite_layer.sv
// Directed and randomized bench for sprite_layer against a pixel-level reference model.
module tb_sprite_layer;

    localparam int          N   = 8;
    localparam int          NP  = 8;
    localparam int          AD  = 2;
    localparam logic [5:0]  ID  = 6'b000011;
    localparam logic [23:0] BG  = 24'h202020;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sprite_layer_if bus();

    sprite_layer #(
        .COMPONENT_ID(ID), .NUM_CHILDREN(N), .NUM_PATTERNS(NP), .PAT_W(16), .PAT_H(16),
        .PALETTE_SIZE(16), .ANIM_DIV(AD), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int mx [2][N], my [2][N], mpat [2][N], mvis [2][N], mflip [2][N], manim [2][N], mfr [2][N];
    int mact, mphase, mfcnt;
    logic [23:0] s1_rgb, exp_rgb;
    logic        s1_hit, exp_hit;
    int tests = 0, fails = 0;

    function automatic logic [23:0] pal(int i);
        return 24'((i << 20) | (10 << 16) | (((16 * i) % 256) << 8) | (255 - i));
    endfunction

    function automatic void model_reset();
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < N; c++) begin
                mx[b][c] = 0; my[b][c] = 0; mpat[b][c] = 0; mvis[b][c] = 0;
                mflip[b][c] = 0; manim[b][c] = 0; mfr[b][c] = 1;
            end
        mact = 0; mphase = 0; mfcnt = 0;
    endfunction

    function automatic void model_write(logic [31:0] w);
        int id, ch, ctrl, typ, b, d;
        id = int'(w[31:26]); ch = int'(w[25:21]); ctrl = int'(w[20:17]);
        typ = int'(w[16:14]); b = int'(w[13]); d = int'(w[12:0]);
        if (ctrl == 15) begin
            mact = b;
            for (int c = 0; c < N; c++) mvis[1-b][c] = 0;
        end else if (ctrl == 1 && id == int'(ID) && ch < N) begin
            case (typ)
                0: mx[b][ch] = d % 1024;
                1: my[b][ch] = d % 1024;
                2: if ((d % 32) < NP) begin
                    mvis[b][ch] = (d >> 12) & 1; mflip[b][ch] = (d >> 11) & 1; mpat[b][ch] = d % 32;
                end
                3: begin
                    manim[b][ch] = (d >> 12) & 1;
                    mfr[b][ch] = ((d % 16) == 0) ? 1 : d % 16;
                end
                default: ;
            endcase
        end
    endfunction

    task automatic model_pixel(input int h, input int v, output logic [23:0] rgb, output logic hit);
        int col, row, ep, idx;
        rgb = BG; hit = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (!hit && mvis[mact][c] == 1 && h >= mx[mact][c] && h < mx[mact][c] + 16
                && v >= my[mact][c] && v < my[mact][c] + 16) begin
                col = h - mx[mact][c];
                if (mflip[mact][c] == 1) col = 15 - col;
                row = v - my[mact][c];
                ep = mpat[mact][c] + ((manim[mact][c] == 1) ? mphase % mfr[mact][c] : 0);
                if (ep >= NP) ep -= NP;
                idx = (col + row + 3 * ep) % 16;
                if (idx != 0) begin hit = 1'b1; rgb = pal(idx); end
            end
        end
    endtask

    // One clock edge: model what the DUT samples, then advance time past the edge.
    task automatic tick();
        logic [23:0] r;
        logic h;
        model_pixel(int'(bus.hcount), int'(bus.vcount), r, h);
        if (!reset) begin
            exp_rgb = BG; exp_hit = 1'b0; s1_rgb = BG; s1_hit = 1'b0;
            model_reset();
        end else begin
            exp_rgb = s1_rgb; exp_hit = s1_hit; s1_rgb = r; s1_hit = h;
            if (bus.write) model_write(bus.writedata);
            if (bus.hcount == 10'd0 && bus.vcount == 10'd0) begin
                mfcnt++;
                if (mfcnt == AD) begin mfcnt = 0; mphase = (mphase + 1) % 16; end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag);
        tests++;
        assert (bus.hit === exp_hit) else begin
            fails++;
            $error("FAIL %s hit: got %b expected %b", tag, bus.hit, exp_hit);
        end
        tests++;
        assert (bus.RGB_output === exp_rgb) else begin
            fails++;
            $error("FAIL %s rgb: got %h expected %h", tag, bus.RGB_output, exp_rgb);
        end
    endtask

    task automatic check_const(input string tag, input logic [23:0] rgb, input logic hit);
        tests++;
        assert (bus.hit === hit && bus.RGB_output === rgb) else begin
            fails++;
            $error("FAIL %s: got hit=%b rgb=%h expected hit=%b rgb=%h",
                   tag, bus.hit, bus.RGB_output, hit, rgb);
        end
    endtask

    function automatic logic [31:0] cmd(logic [5:0] id, int ch, logic [3:0] ctrl, int typ, int b, int d);
        return {id, 5'(ch), ctrl, 3'(typ), 1'(b), 13'(d)};
    endfunction

    task automatic wr(input logic [31:0] w);
        bus.write = 1'b1; bus.writedata = w;
        tick();
        bus.write = 1'b0;
    endtask

    task automatic set_child(input int b, input int c, input int x, input int y,
                             input int pat, input int vis, input int flip);
        wr(cmd(ID, c, 4'h1, 0, b, x));
        wr(cmd(ID, c, 4'h1, 1, b, y));
        wr(cmd(ID, c, 4'h1, 2, b, (vis << 12) | (flip << 11) | pat));
    endtask

    task automatic swap(input int b);
        wr(cmd(6'h00, 0, 4'hF, 0, b, 0));
    endtask

    task automatic pix(input int h, input int v);
        bus.hcount = 10'(h); bus.vcount = 10'(v);
        tick(); tick();
    endtask

    initial begin
        int exp_idx [4];
        exp_idx[0] = 3; exp_idx[1] = 6; exp_idx[2] = 1; exp_idx[3] = 3;
        bus.write = 1'b0; bus.writedata = '0; bus.hcount = 10'd1023; bus.vcount = 10'd1023;

        wr(cmd(ID, 0, 4'h1, 0, 0, 100));
        tick(); tick();
        check("reset"); check_const("reset_bg", BG, 1'b0);
        reset = 1'b1;

        set_child(0, 0, 100, 50, 2, 1, 0);
        swap(0);
        pix(108, 58); check("basic"); check_const("basic_c", pal(6), 1'b1);

        set_child(0, 3, 100, 50, 5, 1, 0);
        pix(108, 58); check("prio0"); check_const("prio0_c", pal(6), 1'b1);
        wr(cmd(ID, 0, 4'h1, 2, 0, 2));
        pix(108, 58); check("prio3"); check_const("prio3_c", pal(15), 1'b1);
        pix(101, 50); check("transp"); check_const("transp_c", BG, 1'b0);

        set_child(0, 1, 0, 200, 1, 1, 1);
        pix(0, 205);  check_const("flip_h0", pal(7), 1'b1);
        pix(15, 205); check_const("flip_h15", pal(8), 1'b1);
        pix(16, 205); check_const("flip_h16", BG, 1'b0);

        bus.hcount = 10'd15; tick();
        bus.hcount = 10'd16; tick();
        check_const("lat_a", pal(8), 1'b1);
        tick();
        check("lat_b"); check_const("lat_b_c", BG, 1'b0);

        set_child(0, 2, 300, 300, 6, 1, 0);
        wr(cmd(ID, 2, 4'h1, 3, 0, (1 << 12) | 3));
        for (int s = 0; s < 4; s++) begin
            if (s > 0) begin
                bus.hcount = 10'd0; bus.vcount = 10'd0;
                repeat (AD) tick();
            end
            pix(301, 300);
            check("anim"); check_const("anim_c", pal(exp_idx[s]), 1'b1);
        end
        wr(cmd(ID, 2, 4'h1, 3, 0, (1 << 12) | 0));
        pix(301, 300); check_const("frames0", pal(3), 1'b1);

        set_child(1, 0, 400, 400, 3, 1, 0);
        pix(405, 405); check_const("buf1_hidden", BG, 1'b0);
        swap(1);
        pix(405, 405); check("buf1_live"); check_const("buf1_live_c", pal(3), 1'b1);
        swap(0);
        pix(108, 58);  check_const("buf0_clr_a", BG, 1'b0);
        pix(301, 300); check_const("buf0_clr_b", BG, 1'b0);

        set_child(0, 0, 100, 50, 2, 1, 0);
        wr(cmd(ID, 0, 4'h1, 2, 0, 8));
        wr(cmd(ID ^ 6'h01, 0, 4'h1, 0, 0, 500));
        wr(cmd(ID, 0, 4'h2, 0, 0, 500));
        wr(cmd(ID, 8, 4'h1, 0, 0, 500));
        pix(108, 58); check("ignored"); check_const("ignored_c", pal(6), 1'b1);

        reset = 1'b0; tick();
        check("rst_mid"); check_const("rst_mid_c", BG, 1'b0);
        reset = 1'b1;
        tick(); check("rst_rel1");
        tick(); check("rst_rel2");

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                int typ, d;
                logic [3:0] ctrl;
                typ = int'($urandom_range(0, 4));
                case (typ)
                    0, 1: d = int'($urandom_range(0, 60));
                    2:    d = int'(($urandom_range(0, 3) << 11) | $urandom_range(0, 9));
                    default: d = int'($urandom_range(0, 8191));
                endcase
                case ($urandom_range(0, 9))
                    0:       ctrl = 4'hF;
                    1:       ctrl = 4'($urandom_range(0, 15));
                    default: ctrl = 4'h1;
                endcase
                bus.write = 1'b1;
                bus.writedata = cmd(($urandom_range(0, 7) == 0) ? 6'($urandom) : ID,
                                    int'($urandom_range(0, 9)), ctrl, typ,
                                    int'($urandom_range(0, 1)), d);
            end
            if ($urandom_range(0, 19) == 0) begin
                bus.hcount = 10'd0; bus.vcount = 10'd0;
            end else begin
                bus.hcount = 10'($urandom_range(0, 79)); bus.vcount = 10'($urandom_range(0, 79));
            end
            tick();
            bus.write = 1'b0;
            check("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
